// File: rtl/axi_burst_check_master.sv
// AXI4 master that writes one 16-beat seeded pattern burst, reads it back and
// reports pass/fail with mismatch, response and RLAST error indications.
module axi_burst_check_master #(
  parameter int unsigned C_ADDR_WIDTH = 32,
  parameter int unsigned C_DATA_WIDTH = 32,
  parameter int unsigned C_ID_WIDTH   = 1,
  parameter int unsigned C_READ_WRAP  = 1
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  input  logic                      start,
  input  logic [C_ADDR_WIDTH-1:0]   start_addr,
  input  logic [31:0]               seed,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic [4:0]                mismatch_cnt,
  output logic                      resp_err,
  output logic                      last_err,
  output logic [C_ID_WIDTH-1:0]     M_AXI_AWID,
  output logic [C_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [7:0]                M_AXI_AWLEN,
  output logic [2:0]                M_AXI_AWSIZE,
  output logic [1:0]                M_AXI_AWBURST,
  output logic                      M_AXI_AWVALID,
  input  logic                      M_AXI_AWREADY,
  output logic [C_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                      M_AXI_WLAST,
  output logic                      M_AXI_WVALID,
  input  logic                      M_AXI_WREADY,
  input  logic [C_ID_WIDTH-1:0]     M_AXI_BID,
  input  logic [1:0]                M_AXI_BRESP,
  input  logic                      M_AXI_BVALID,
  output logic                      M_AXI_BREADY,
  output logic [C_ID_WIDTH-1:0]     M_AXI_ARID,
  output logic [C_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [7:0]                M_AXI_ARLEN,
  output logic [2:0]                M_AXI_ARSIZE,
  output logic [1:0]                M_AXI_ARBURST,
  output logic                      M_AXI_ARVALID,
  input  logic                      M_AXI_ARREADY,
  input  logic [C_ID_WIDTH-1:0]     M_AXI_RID,
  input  logic [C_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                M_AXI_RRESP,
  input  logic                      M_AXI_RLAST,
  input  logic                      M_AXI_RVALID,
  output logic                      M_AXI_RREADY
);

  typedef enum logic [2:0] {
    StIdle,
    StWaddr,
    StWdata,
    StWresp,
    StRaddr,
    StRdata,
    StDone
  } state_e;

  state_e                  state_q, state_d;
  logic [C_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]             seed_q, seed_d;
  logic [3:0]              beat_q, beat_d;
  logic [4:0]              mismatch_q, mismatch_d;
  logic                    resp_err_q, resp_err_d;
  logic                    last_err_q, last_err_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    pass_q, pass_d;
  logic [C_DATA_WIDTH-1:0] pattern;

  // IDs and low address bits are deliberately ignored.
  logic unused_inputs;
  assign unused_inputs = ^{M_AXI_BID, M_AXI_RID, start_addr[5:0]};

  // One counter serves both bursts; it wraps to 0 after the last write beat.
  assign pattern = C_DATA_WIDTH'(seed_q + 32'(beat_q));

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    seed_d     = seed_q;
    beat_d     = beat_q;
    mismatch_d = mismatch_q;
    resp_err_d = resp_err_q;
    last_err_d = last_err_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    pass_d     = pass_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StWaddr;
          addr_d     = {start_addr[C_ADDR_WIDTH-1:6], 6'b0};
          seed_d     = seed;
          beat_d     = 4'd0;
          mismatch_d = 5'd0;
          resp_err_d = 1'b0;
          last_err_d = 1'b0;
          pass_d     = 1'b0;
          busy_d     = 1'b1;
        end
      end
      StWaddr: begin
        if (M_AXI_AWREADY) state_d = StWdata;
      end
      StWdata: begin
        if (M_AXI_WREADY) begin
          beat_d = beat_q + 4'd1;
          if (beat_q == 4'd15) state_d = StWresp;
        end
      end
      StWresp: begin
        if (M_AXI_BVALID) begin
          if (M_AXI_BRESP != 2'b00) resp_err_d = 1'b1;
          state_d = StRaddr;
        end
      end
      StRaddr: begin
        beat_d = 4'd0;
        if (M_AXI_ARREADY) state_d = StRdata;
      end
      StRdata: begin
        if (M_AXI_RVALID) begin
          if (M_AXI_RDATA != pattern) mismatch_d = mismatch_q + 5'd1;
          if (M_AXI_RRESP != 2'b00) resp_err_d = 1'b1;
          beat_d = beat_q + 4'd1;
          // Early RLAST or missing RLAST on beat 15 both end the read.
          if (M_AXI_RLAST != (beat_q == 4'd15)) last_err_d = 1'b1;
          if (M_AXI_RLAST || beat_q == 4'd15) state_d = StDone;
        end
      end
      StDone: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        pass_d  = (mismatch_q == 5'd0) && !resp_err_q && !last_err_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      seed_q     <= '0;
      beat_q     <= '0;
      mismatch_q <= '0;
      resp_err_q <= 1'b0;
      last_err_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      seed_q     <= seed_d;
      beat_q     <= beat_d;
      mismatch_q <= mismatch_d;
      resp_err_q <= resp_err_d;
      last_err_q <= last_err_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign pass         = pass_q;
  assign mismatch_cnt = mismatch_q;
  assign resp_err     = resp_err_q;
  assign last_err     = last_err_q;

  assign M_AXI_AWID    = '0;
  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWLEN   = 8'd15;
  assign M_AXI_AWSIZE  = 3'b010;
  assign M_AXI_AWBURST = 2'b01;
  assign M_AXI_AWVALID = (state_q == StWaddr);

  assign M_AXI_WDATA  = pattern;
  assign M_AXI_WSTRB  = '1;
  assign M_AXI_WLAST  = (beat_q == 4'd15);
  assign M_AXI_WVALID = (state_q == StWdata);

  assign M_AXI_BREADY = (state_q == StWresp);

  assign M_AXI_ARID    = C_ID_WIDTH'(1);
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARLEN   = 8'd15;
  assign M_AXI_ARSIZE  = 3'b010;
  assign M_AXI_ARBURST = (C_READ_WRAP != 0) ? 2'b10 : 2'b01;
  assign M_AXI_ARVALID = (state_q == StRaddr);

  assign M_AXI_RREADY = (state_q == StRdata);

endmodule

// File: tb/tb_axi_burst_check_master.sv
// Self-checking bench: memory-backed AXI slave model with fault injection and
// a result model derived from the configured faults.
module tb_axi_burst_check_master;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        start;
  logic [31:0] start_addr, seed;
  logic        busy, done, pass, resp_err, last_err;
  logic [4:0]  mismatch_cnt;
  logic [0:0]  M_AXI_AWID, M_AXI_BID, M_AXI_ARID, M_AXI_RID;
  logic [31:0] M_AXI_AWADDR, M_AXI_ARADDR, M_AXI_WDATA, M_AXI_RDATA;
  logic [7:0]  M_AXI_AWLEN, M_AXI_ARLEN;
  logic [2:0]  M_AXI_AWSIZE, M_AXI_ARSIZE;
  logic [1:0]  M_AXI_AWBURST, M_AXI_ARBURST, M_AXI_BRESP, M_AXI_RRESP;
  logic [3:0]  M_AXI_WSTRB;
  logic        M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WLAST, M_AXI_WVALID, M_AXI_WREADY;
  logic        M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
  logic        M_AXI_RLAST, M_AXI_RVALID, M_AXI_RREADY;

  always #5 ACLK = ~ACLK;

  axi_burst_check_master dut (
    .ACLK(ACLK), .ARESET(ARESET), .start(start), .start_addr(start_addr), .seed(seed),
    .busy(busy), .done(done), .pass(pass), .mismatch_cnt(mismatch_cnt),
    .resp_err(resp_err), .last_err(last_err),
    .M_AXI_AWID(M_AXI_AWID), .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWLEN(M_AXI_AWLEN),
    .M_AXI_AWSIZE(M_AXI_AWSIZE), .M_AXI_AWBURST(M_AXI_AWBURST),
    .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WLAST(M_AXI_WLAST),
    .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_BID(M_AXI_BID), .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID),
    .M_AXI_BREADY(M_AXI_BREADY),
    .M_AXI_ARID(M_AXI_ARID), .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARLEN(M_AXI_ARLEN),
    .M_AXI_ARSIZE(M_AXI_ARSIZE), .M_AXI_ARBURST(M_AXI_ARBURST),
    .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RID(M_AXI_RID), .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
    .M_AXI_RLAST(M_AXI_RLAST), .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Slave configuration
  int          cfg_stall;
  bit          cfg_w_toggle;
  logic [1:0]  cfg_bresp;
  logic [15:0] cfg_corrupt, cfg_rresp_err;
  logic [31:0] cfg_bad_data [16];
  int          cfg_rlast_beat;  // 0..14 early, 15 normal, 16 never asserted

  // Slave observations
  int          aw_cnt, ar_cnt, w_cnt, r_sent, done_cnt, stab_viol, aw_drop;
  logic [31:0] aw_addr_l, ar_addr_l;
  logic [7:0]  aw_len_l, ar_len_l;
  logic [2:0]  aw_size_l, ar_size_l;
  logic [1:0]  aw_burst_l, ar_burst_l;
  logic        aw_id_l, ar_id_l;
  logic [31:0] wdata_log [16];
  logic        wlast_log [16];
  logic [3:0]  wstrb_l;
  logic [31:0] mem [logic [31:0]];

  // Slave internals
  bit          slv_clr = 1'b0;
  bit          aw_hs, w_hs, b_hs, ar_hs, r_hs, b_pend, r_active, rhold, w_stalled, aw_wait;
  int          r_beat;
  logic [31:0] hs_awaddr, hs_araddr, hs_wdata, w_prev_data;
  logic [7:0]  hs_awlen, hs_arlen;
  logic [2:0]  hs_awsize, hs_arsize;
  logic [1:0]  hs_awburst, hs_arburst;
  logic        hs_awid, hs_arid, hs_wlast, w_prev_last;

  function automatic logic rnd_ready();
    return (cfg_stall == 0) || ($urandom_range(99) >= cfg_stall);
  endfunction

  // Slave acts at falling edges: commits handshakes seen at the last rising
  // edge, then drives new inputs and decides the handshakes of the next edge.
  initial begin : slave
    M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_BVALID = 0; M_AXI_ARREADY = 0;
    M_AXI_RVALID = 0; M_AXI_RDATA = 0; M_AXI_RRESP = 0; M_AXI_RLAST = 0;
    M_AXI_BRESP = 0; M_AXI_BID = 1'b0; M_AXI_RID = 1'b1;
    forever begin
      @(negedge ACLK);
      if (slv_clr) begin
        M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_BVALID = 0; M_AXI_ARREADY = 0;
        M_AXI_RVALID = 0; M_AXI_RLAST = 0;
        {aw_hs, w_hs, b_hs, ar_hs, r_hs, b_pend, r_active, w_stalled, aw_wait} = '0;
        aw_cnt = 0; ar_cnt = 0; w_cnt = 0; r_sent = 0; done_cnt = 0;
        stab_viol = 0; aw_drop = 0; r_beat = 0;
        mem.delete();
        slv_clr = 1'b0;
      end else begin
        if (aw_hs) begin
          aw_cnt++; aw_addr_l = hs_awaddr; aw_len_l = hs_awlen; aw_size_l = hs_awsize;
          aw_burst_l = hs_awburst; aw_id_l = hs_awid;
        end
        if (w_hs) begin
          if (w_cnt < 16) begin wdata_log[w_cnt] = hs_wdata; wlast_log[w_cnt] = hs_wlast; end
          mem[aw_addr_l + 32'(4 * w_cnt)] = hs_wdata;
          w_cnt++;
          if (hs_wlast) b_pend = 1'b1;
        end
        if (b_hs) b_pend = 1'b0;
        if (ar_hs) begin
          ar_cnt++; ar_addr_l = hs_araddr; ar_len_l = hs_arlen; ar_size_l = hs_arsize;
          ar_burst_l = hs_arburst; ar_id_l = hs_arid; r_active = 1'b1; r_beat = 0;
        end
        if (r_hs) begin
          r_sent++;
          if (r_beat == ((cfg_rlast_beat < 15) ? cfg_rlast_beat : 15)) r_active = 1'b0;
          r_beat++;
        end
        if (done) done_cnt++;
        if (w_stalled && M_AXI_WVALID &&
            (M_AXI_WDATA !== w_prev_data || M_AXI_WLAST !== w_prev_last)) stab_viol++;
        if (aw_wait && !M_AXI_AWVALID) aw_drop++;

        M_AXI_AWREADY = rnd_ready();
        M_AXI_WREADY  = cfg_w_toggle ? !M_AXI_WREADY : rnd_ready();
        M_AXI_ARREADY = rnd_ready();
        M_AXI_BRESP   = cfg_bresp;
        M_AXI_BVALID  = b_pend && (M_AXI_BVALID || rnd_ready());
        rhold         = M_AXI_RVALID && !r_hs;
        M_AXI_RVALID  = r_active && (rhold || rnd_ready());
        if (r_active) begin
          if (cfg_corrupt[r_beat]) M_AXI_RDATA = cfg_bad_data[r_beat];
          else if (mem.exists(ar_addr_l + 32'(4 * r_beat)))
            M_AXI_RDATA = mem[ar_addr_l + 32'(4 * r_beat)];
          else M_AXI_RDATA = 32'h0BAD_0000;
          M_AXI_RRESP = cfg_rresp_err[r_beat] ? 2'b10 : 2'b00;
          M_AXI_RLAST = (r_beat == cfg_rlast_beat);
        end else begin
          M_AXI_RLAST = 1'b0;
        end

        aw_hs = M_AXI_AWVALID && M_AXI_AWREADY;
        hs_awaddr = M_AXI_AWADDR; hs_awlen = M_AXI_AWLEN; hs_awsize = M_AXI_AWSIZE;
        hs_awburst = M_AXI_AWBURST; hs_awid = M_AXI_AWID;
        w_hs = M_AXI_WVALID && M_AXI_WREADY;
        hs_wdata = M_AXI_WDATA; hs_wlast = M_AXI_WLAST;
        if (w_hs) wstrb_l = M_AXI_WSTRB;
        b_hs = M_AXI_BVALID && M_AXI_BREADY;
        ar_hs = M_AXI_ARVALID && M_AXI_ARREADY;
        hs_araddr = M_AXI_ARADDR; hs_arlen = M_AXI_ARLEN; hs_arsize = M_AXI_ARSIZE;
        hs_arburst = M_AXI_ARBURST; hs_arid = M_AXI_ARID;
        r_hs = M_AXI_RVALID && M_AXI_RREADY;
        w_stalled = M_AXI_WVALID && !M_AXI_WREADY;
        w_prev_data = M_AXI_WDATA; w_prev_last = M_AXI_WLAST;
        aw_wait = M_AXI_AWVALID && !M_AXI_AWREADY;
      end
    end
  end

  // Expected outcome from the injected faults alone.
  typedef struct {
    int mism;
    bit rerr;
    bit lerr;
    bit pass;
    int rbeats;
  } exp_t;

  function automatic exp_t model(logic [31:0] sd);
    exp_t e;
    e.rbeats = (cfg_rlast_beat < 15) ? cfg_rlast_beat + 1 : 16;
    e.mism = 0;
    e.rerr = (cfg_bresp != 2'b00);
    for (int k = 0; k < e.rbeats; k++) begin
      if (cfg_corrupt[k] && cfg_bad_data[k] != sd + 32'(k)) e.mism++;
      if (cfg_rresp_err[k]) e.rerr = 1'b1;
    end
    e.lerr = (cfg_rlast_beat != 15);
    e.pass = (e.mism == 0) && !e.rerr && !e.lerr;
    return e;
  endfunction

  task automatic tick();
    @(negedge ACLK);
    #1;
  endtask

  task automatic new_test();
    cfg_stall = 0; cfg_w_toggle = 0; cfg_bresp = 2'b00; cfg_corrupt = '0;
    cfg_rresp_err = '0; cfg_rlast_beat = 15;
    for (int k = 0; k < 16; k++) cfg_bad_data[k] = 32'hDEAD_BEEF;
    slv_clr = 1'b1;
    tick();
    tick();
  endtask

  task automatic run_check(input logic [31:0] a, input logic [31:0] s, output int cyc);
    start_addr = a; seed = s; start = 1'b1; cyc = 0;
    do begin
      tick();
      start = 1'b0;
      cyc++;
    end while (done !== 1'b1 && cyc < 3000);
    n_checks++;
    if (done !== 1'b1) begin
      n_errors++;
      $display("FAIL done_timeout got done=%b after %0d cycles, required 1", done, cyc);
      ARESET = 1'b1; tick(); ARESET = 1'b0;
    end
  endtask

  task automatic test_reset();
    ARESET = 1'b1; start = 1'b0; start_addr = '0; seed = '0;
    new_test();
    tick();
    n_checks++;
    if ({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY} !== 5'b0) begin
      n_errors++;
      $display("FAIL reset_handshakes got %b%b%b%b%b required 00000", M_AXI_AWVALID,
               M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY);
    end
    n_checks++;
    if ({busy, done, pass, resp_err, last_err} !== 5'b0 || mismatch_cnt !== 5'd0) begin
      n_errors++;
      $display("FAIL reset_status got busy%b done%b pass%b rerr%b lerr%b mism%0d required 0",
               busy, done, pass, resp_err, last_err, mismatch_cnt);
    end
    ARESET = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int cyc;
    exp_t e;
    new_test();
    run_check(32'h0, 32'h1000_0000, cyc);
    e = model(32'h1000_0000);
    n_checks++;
    if (cyc != 37) begin n_errors++; $display("FAIL basic_latency got %0d required 37", cyc); end
    n_checks++;
    if ({aw_addr_l, aw_len_l, aw_size_l, aw_burst_l, aw_id_l, wstrb_l} !==
        {32'h0, 8'd15, 3'b010, 2'b01, 1'b0, 4'hF}) begin
      n_errors++;
      $display("FAIL basic_aw got addr %h len %0d size %b burst %b id %b strb %h required 0/15/010/01/0/f",
               aw_addr_l, aw_len_l, aw_size_l, aw_burst_l, aw_id_l, wstrb_l);
    end
    n_checks++;
    if ({ar_addr_l, ar_len_l, ar_size_l, ar_burst_l, ar_id_l} !==
        {32'h0, 8'd15, 3'b010, 2'b10, 1'b1}) begin
      n_errors++;
      $display("FAIL basic_ar got addr %h len %0d size %b burst %b id %b required 0/15/010/10/1",
               ar_addr_l, ar_len_l, ar_size_l, ar_burst_l, ar_id_l);
    end
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (wdata_log[i] !== 32'h1000_0000 + 32'(i) || wlast_log[i] !== (i == 15)) begin
        n_errors++;
        $display("FAIL basic_wbeat%0d got %h last %b required %h last %b", i, wdata_log[i],
                 wlast_log[i], 32'h1000_0000 + 32'(i), (i == 15));
      end
    end
    n_checks++;
    if (pass !== e.pass || mismatch_cnt !== 5'(e.mism) || resp_err !== e.rerr ||
        last_err !== e.lerr) begin
      n_errors++;
      $display("FAIL basic_result got pass%b mism%0d rerr%b lerr%b required pass%b mism%0d",
               pass, mismatch_cnt, resp_err, last_err, e.pass, e.mism);
    end
    n_checks++;
    if (busy !== 1'b0) begin n_errors++; $display("FAIL basic_busy got %b required 0", busy); end
    tick();
    n_checks++;
    if (done !== 1'b0 || pass !== 1'b1) begin
      n_errors++;
      $display("FAIL basic_pulse got done%b pass%b required done0 pass1", done, pass);
    end
  endtask

  // Single fault scenario: apply the given faults, run, compare to the model.
  task automatic test_fault(input string name, input logic [1:0] bresp, input int corrupt_beat,
                            input int rlast_beat);
    int cyc;
    exp_t e;
    logic [31:0] s;
    new_test();
    s = 32'h1000_0000;
    cfg_bresp = bresp;
    cfg_rlast_beat = rlast_beat;
    if (corrupt_beat >= 0) cfg_corrupt[corrupt_beat] = 1'b1;
    run_check(32'h0000_1000, s, cyc);
    e = model(s);
    n_checks++;
    if (pass !== e.pass || mismatch_cnt !== 5'(e.mism) || resp_err !== e.rerr ||
        last_err !== e.lerr) begin
      n_errors++;
      $display("FAIL %s got pass%b mism%0d rerr%b lerr%b required pass%b mism%0d rerr%b lerr%b",
               name, pass, mismatch_cnt, resp_err, last_err, e.pass, e.mism, e.rerr, e.lerr);
    end
    n_checks++;
    if (r_sent != e.rbeats) begin
      n_errors++;
      $display("FAIL %s_rbeats got %0d required %0d", name, r_sent, e.rbeats);
    end
  endtask

  task automatic test_wready_toggle();
    int cyc;
    new_test();
    cfg_w_toggle = 1'b1;
    run_check(32'h0000_0044, 32'hFFFF_FFF8, cyc);
    n_checks++;
    if (aw_addr_l !== 32'h40 || ar_addr_l !== 32'h40) begin
      n_errors++;
      $display("FAIL toggle_addr got aw %h ar %h required 40", aw_addr_l, ar_addr_l);
    end
    n_checks++;
    if (stab_viol != 0) begin
      n_errors++; $display("FAIL toggle_stable got %0d changes required 0", stab_viol);
    end
    n_checks++;
    if (wdata_log[9] !== 32'h0000_0001 || pass !== 1'b1 || mismatch_cnt !== 5'd0) begin
      n_errors++;
      $display("FAIL toggle_result got w9 %h pass%b mism%0d required 00000001 pass1 mism0",
               wdata_log[9], pass, mismatch_cnt);
    end
  endtask

  task automatic test_reset_mid_read();
    int n, cyc;
    new_test();
    start_addr = 32'h200; seed = 32'h55; start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (r_sent < 3 && n < 500) begin tick(); n++; end
    n_checks++;
    if (r_sent != 3) begin
      n_errors++; $display("FAIL rst_reach_beat3 got %0d beats required 3", r_sent);
    end
    ARESET = 1'b1;
    slv_clr = 1'b1;
    tick();
    n_checks++;
    if (M_AXI_RREADY !== 1'b0 || busy !== 1'b0 || pass !== 1'b0) begin
      n_errors++;
      $display("FAIL rst_mid_read got rready%b busy%b pass%b required 000", M_AXI_RREADY,
               busy, pass);
    end
    ARESET = 1'b0;
    tick();
    run_check(32'h0000_0300, 32'hA5A5_0000, cyc);
    n_checks++;
    if (pass !== 1'b1 || aw_cnt != 1) begin
      n_errors++;
      $display("FAIL rst_rerun got pass%b aw%0d required pass1 aw1", pass, aw_cnt);
    end
  endtask

  task automatic test_start_while_busy();
    int n;
    new_test();
    start_addr = 32'h80; seed = 32'h7; start = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
      start = (n == 10) || (n == 36);  // second start mid-run, third in the DONE cycle
    end while (done !== 1'b1 && n < 500);
    start = 1'b0;
    repeat (60) tick();
    n_checks++;
    if (aw_cnt != 1 || ar_cnt != 1 || done_cnt != 1) begin
      n_errors++;
      $display("FAIL busy_start got aw%0d ar%0d done%0d required 1 1 1", aw_cnt, ar_cnt,
               done_cnt);
    end
    n_checks++;
    if (busy !== 1'b0 || pass !== 1'b1) begin
      n_errors++; $display("FAIL busy_final got busy%b pass%b required 0 1", busy, pass);
    end
  endtask

  task automatic test_random();
    int cyc, r;
    exp_t e;
    logic [31:0] a, s;
    for (int it = 0; it < 12; it++) begin
      new_test();
      cfg_stall = $urandom_range(50);
      r = $urandom_range(3);
      cfg_corrupt = (r == 0) ? (16'(1) << $urandom_range(15)) : (r == 1) ? 16'($urandom) : 16'h0;
      for (int k = 0; k < 16; k++) cfg_bad_data[k] = $urandom;
      cfg_bresp = ($urandom_range(5) == 0) ? 2'b10 : 2'b00;
      cfg_rresp_err = ($urandom_range(5) == 0) ? (16'(1) << $urandom_range(15)) : 16'h0;
      r = $urandom_range(7);
      cfg_rlast_beat = (r == 0) ? int'($urandom_range(14)) : (r == 1) ? 16 : 15;
      a = $urandom; s = $urandom;
      run_check(a, s, cyc);
      e = model(s);
      n_checks++;
      if (aw_addr_l !== (a & ~32'h3F) || ar_addr_l !== (a & ~32'h3F)) begin
        n_errors++;
        $display("FAIL rnd%0d_addr got aw %h ar %h required %h", it, aw_addr_l, ar_addr_l,
                 a & ~32'h3F);
      end
      for (int i = 0; i < 16; i++) begin
        n_checks++;
        if (wdata_log[i] !== s + 32'(i) || wlast_log[i] !== (i == 15)) begin
          n_errors++;
          $display("FAIL rnd%0d_wbeat%0d got %h last %b required %h", it, i, wdata_log[i],
                   wlast_log[i], s + 32'(i));
        end
      end
      n_checks++;
      if (pass !== e.pass || mismatch_cnt !== 5'(e.mism) || resp_err !== e.rerr ||
          last_err !== e.lerr) begin
        n_errors++;
        $display("FAIL rnd%0d_result got pass%b mism%0d rerr%b lerr%b required %b %0d %b %b",
                 it, pass, mismatch_cnt, resp_err, last_err, e.pass, e.mism, e.rerr, e.lerr);
      end
      n_checks++;
      if (r_sent != e.rbeats || stab_viol != 0 || aw_drop != 0) begin
        n_errors++;
        $display("FAIL rnd%0d_proto got rbeats %0d stab %0d awdrop %0d required %0d 0 0",
                 it, r_sent, stab_viol, aw_drop, e.rbeats);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fault("bad_beat5", 2'b00, 5, 15);
    test_fault("bresp_slverr", 2'b10, -1, 15);
    test_fault("early_rlast7", 2'b00, -1, 7);
    test_fault("missing_rlast", 2'b00, -1, 16);
    test_wready_toggle();
    test_reset_mid_read();
    test_start_while_busy();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/axi_burst_check_master.md
Name: axi_burst_check_master

Overview:
- AXI4 full master that sequences a single 16-beat write/read-back check against the AXI4 full slave (S00_AXI) datapath.
- On a start pulse it issues one INCR write burst of a seeded data pattern, then one read burst (WRAP or INCR) of the same region. It compares every returned beat and reports pass/fail plus error counts.
- Sits in front of the slave as the on-chip replacement for the bench BFM. Intended for built-in self-test after reset.

Parameters:
- C_ADDR_WIDTH, 32, address width
- C_DATA_WIDTH, 32, data width; only 32 supported (AxSIZE fixed 3'b010)
- C_ID_WIDTH, 1, AXI ID width
- C_READ_WRAP, 1, 1: ARBURST=WRAP (2'b10); 0: ARBURST=INCR (2'b01)

Ports:
- ACLK  in  1  clock, all logic on rising edge
- ARESET  in  1  synchronous reset, active-high
- start  in  1  one-cycle request to run a check
- start_addr  in  C_ADDR_WIDTH  base address; bits [5:0] forced to 0 internally
- seed  in  32  pattern seed
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse at end of check
- pass  out  1  result of last check; held until next accepted start
- mismatch_cnt  out  5  count of data-mismatch beats (0..16)
- resp_err  out  1  BRESP or any RRESP != OKAY
- last_err  out  1  RLAST misplaced or missing
- M_AXI_AWID/AWADDR/AWLEN/AWSIZE/AWBURST  out  C_ID_WIDTH/C_ADDR_WIDTH/8/3/2  write address
- M_AXI_AWVALID out 1; M_AXI_AWREADY in 1
- M_AXI_WDATA/WSTRB/WLAST/WVALID  out  32/4/1/1; M_AXI_WREADY in 1
- M_AXI_BID/BRESP/BVALID  in  C_ID_WIDTH/2/1; M_AXI_BREADY out 1
- M_AXI_ARID/ARADDR/ARLEN/ARSIZE/ARBURST  out  C_ID_WIDTH/C_ADDR_WIDTH/8/3/2  read address
- M_AXI_ARVALID out 1; M_AXI_ARREADY in 1
- M_AXI_RID/RDATA/RRESP/RLAST/RVALID  in  C_ID_WIDTH/32/2/1/1; M_AXI_RREADY out 1

Behaviour:
- Reset (ARESET=1 at edge): state IDLE. All VALID/READY outputs 0, busy=0, done=0, pass=0, mismatch_cnt=0, resp_err=0, last_err=0, beat counter 0. Reset mid-burst abandons the transaction immediately; the slave is not drained.
- Constants: AWLEN=ARLEN=8'd15, AxSIZE=3'b010, AWBURST=2'b01, WSTRB=4'hF, AWID=0, ARID=1.
- Address: addr_q = {start_addr[C_ADDR_WIDTH-1:6], 6'b0}, latched on start. This alignment makes WRAP beat order equal to INCR order.
- Pattern: beat i (0..15) data = seed + i, 32-bit modulo add. Seed is latched on start.
- FSM and transitions:
  - IDLE: start → WADDR. Latch addr/seed, clear counters and flags, busy=1 on the next cycle.
  - WADDR: AWVALID=1 until AWVALID&AWREADY → WDATA. AWVALID must not drop before the handshake.
  - WDATA: WVALID=1, WDATA=pattern(beat), WLAST=(beat==15). Beat advances only on WVALID&WREADY; data holds stable while stalled. Handshake on beat 15 → WRESP.
  - WRESP: BREADY=1. On BVALID: BRESP!=2'b00 sets resp_err; go to RADDR.
  - RADDR: ARVALID=1 until ARREADY → RDATA.
  - RDATA: RREADY=1. On each RVALID beat k, RDATA != seed+k increments mismatch_cnt, and RRESP!=00 sets resp_err. RLAST with k<15 sets last_err and ends the read (→ DONE). Beat 15 without RLAST sets last_err and goes to DONE.
  - DONE: done=1 for one cycle, busy→0, pass = (mismatch_cnt==0)&!resp_err&!last_err, computed including the final beat → IDLE.
- start while busy is ignored. start in the DONE cycle is ignored.
- Minimum latency with all READY tied high: start → done = 1 (AW) + 16 (W) + 1 (B) + 1 (AR) + 16 (R) + 1 = 36 cycles, plus 1 cycle for IDLE→WADDR.
- mismatch_cnt saturates at 16 by construction; no wrap.
- BID/RID are not checked.

Test Plan:
- Slave model with all READYs high, seed=32'h1000_0000, start_addr=0 → AWADDR=0, AWLEN=15, WDATA 0x10000000..0x1000000F, ARBURST=2'b10; done 37 cycles after start; pass=1, mismatch_cnt=0.
- Slave returns beat 5 as 0xDEADBEEF → mismatch_cnt=1, pass=0, resp_err=0.
- BRESP=2'b10 (SLVERR), data correct → resp_err=1, pass=0. RLAST asserted on beat 7 → last_err=1, done after 8 R beats.
- WREADY toggling every other cycle, start_addr=32'h0000_0044 → AWADDR=0x40; WDATA/WLAST stable during stalls; pass=1.
- ARESET pulsed during RDATA beat 3 → next cycle RREADY=0, busy=0, pass=0. A fresh start then completes with pass=1.
- Second start pulse while busy, 10 cycles after the first → ignored: exactly one AW and one AR handshake, one done pulse.
